// File: rtl/matmul_tile_sequencer.sv
// Walks the m/n/k tile loops of a tiled GEMM and drives one systolic matmul kernel call per tile.
// Addresses come from running adders; edge-tile masks come from the latched remainders.
module matmul_tile_sequencer #(
   parameter int AWIDTH            = 10,
   parameter int ADDR_STRIDE_WIDTH = 8,
   parameter int MASK_WIDTH        = 32,
   parameter int TILE              = 32,
   parameter int CNT_W             = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [CNT_W-1:0]             num_tiles_m,
   input  logic [CNT_W-1:0]             num_tiles_n,
   input  logic [CNT_W-1:0]             num_tiles_k,
   input  logic [5:0]                   rem_m,
   input  logic [5:0]                   rem_n,
   input  logic [5:0]                   rem_k,
   input  logic [AWIDTH-1:0]            base_a,
   input  logic [AWIDTH-1:0]            base_b,
   input  logic [AWIDTH-1:0]            base_c,
   input  logic [ADDR_STRIDE_WIDTH-1:0] stride_a,
   input  logic [ADDR_STRIDE_WIDTH-1:0] stride_b,
   input  logic [ADDR_STRIDE_WIDTH-1:0] stride_c,
   output logic                         busy,
   output logic                         done,
   output logic                         start_mat_mul,
   output logic                         pe_reset,
   input  logic                         done_mat_mul,
   output logic [AWIDTH-1:0]            address_mat_a,
   output logic [AWIDTH-1:0]            address_mat_b,
   output logic [AWIDTH-1:0]            address_mat_c,
   output logic [ADDR_STRIDE_WIDTH-1:0] address_stride_a,
   output logic [ADDR_STRIDE_WIDTH-1:0] address_stride_b,
   output logic [ADDR_STRIDE_WIDTH-1:0] address_stride_c,
   output logic [MASK_WIDTH-1:0]        validity_mask_a_rows,
   output logic [MASK_WIDTH-1:0]        validity_mask_a_cols,
   output logic [MASK_WIDTH-1:0]        validity_mask_b_rows,
   output logic [MASK_WIDTH-1:0]        validity_mask_b_cols
);

   typedef enum logic [2:0] {IDLE, CLR, RUN, STEP, FIN} state_t;

   localparam logic [AWIDTH-1:0] TSTEP = AWIDTH'(TILE);
   localparam logic [CNT_W-1:0]  ONE   = CNT_W'(1);

   state_t            state;
   logic [CNT_W-1:0]  mt, nt, kt, mi, ni, ki;
   logic [CNT_W-1:0]  mi_n, ni_n, ki_n;
   logic [5:0]        rm, rn, rk;
   logic [AWIDTH-1:0] bb, a_row;
   logic              k_last, n_last, m_last;

   // A partial mask only applies to the last tile of a dimension with 0 < r < 32.
   function automatic logic [MASK_WIDTH-1:0] edge_mask(input logic last, input logic [5:0] r);
      logic [MASK_WIDTH-1:0] mk;
      for (int i = 0; i < MASK_WIDTH; i++)
         mk[i] = !(last && r != 6'd0 && r < 6'd32) || (i < int'(r));
      return mk;
   endfunction

   assign k_last = (ki == kt - ONE);
   assign n_last = (ni == nt - ONE);
   assign m_last = (mi == mt - ONE);

   always_comb begin
      ki_n = k_last ? '0 : ki + ONE;
      ni_n = ni;
      mi_n = mi;
      if (k_last) begin
         if (n_last) begin
            ni_n = '0;
            mi_n = mi + ONE;
         end else begin
            ni_n = ni + ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state                <= IDLE;
         busy                 <= 1'b0;
         done                 <= 1'b0;
         start_mat_mul        <= 1'b0;
         pe_reset             <= 1'b0;
         {mt, nt, kt, mi, ni, ki} <= '0;
         {rm, rn, rk}         <= '0;
         bb                   <= '0;
         a_row                <= '0;
         address_mat_a        <= '0;
         address_mat_b        <= '0;
         address_mat_c        <= '0;
         address_stride_a     <= '0;
         address_stride_b     <= '0;
         address_stride_c     <= '0;
         validity_mask_a_rows <= '0;
         validity_mask_a_cols <= '0;
         validity_mask_b_rows <= '0;
         validity_mask_b_cols <= '0;
      end else begin
         case (state)
            IDLE: begin
               // busy stays up through the done cycle, so a start there is ignored
               done <= 1'b0;
               busy <= 1'b0;
               if (start && !busy) begin
                  busy             <= 1'b1;
                  mt               <= num_tiles_m;
                  nt               <= num_tiles_n;
                  kt               <= num_tiles_k;
                  rm               <= rem_m;
                  rn               <= rem_n;
                  rk               <= rem_k;
                  {mi, ni, ki}     <= '0;
                  bb               <= base_b;
                  a_row            <= base_a;
                  address_mat_a    <= base_a;
                  address_mat_b    <= base_b;
                  address_mat_c    <= base_c;
                  address_stride_a <= stride_a;
                  address_stride_b <= stride_b;
                  address_stride_c <= stride_c;
                  validity_mask_a_rows <= edge_mask(num_tiles_m == ONE, rem_m);
                  validity_mask_a_cols <= edge_mask(num_tiles_k == ONE, rem_k);
                  validity_mask_b_rows <= edge_mask(num_tiles_k == ONE, rem_k);
                  validity_mask_b_cols <= edge_mask(num_tiles_n == ONE, rem_n);
                  if (num_tiles_m == '0 || num_tiles_n == '0 || num_tiles_k == '0) begin
                     state <= FIN;
                  end else begin
                     pe_reset <= 1'b1;
                     state    <= CLR;
                  end
               end
            end
            CLR: begin
               pe_reset      <= 1'b0;
               start_mat_mul <= 1'b1;
               state         <= RUN;
            end
            RUN: begin
               if (done_mat_mul) begin
                  start_mat_mul <= 1'b0;
                  state         <= STEP;
               end
            end
            STEP: begin
               ki <= ki_n;
               ni <= ni_n;
               mi <= mi_n;
               validity_mask_a_rows <= edge_mask(mi_n == mt - ONE, rm);
               validity_mask_a_cols <= edge_mask(ki_n == kt - ONE, rk);
               validity_mask_b_rows <= edge_mask(ki_n == kt - ONE, rk);
               validity_mask_b_cols <= edge_mask(ni_n == nt - ONE, rn);
               if (!k_last) begin
                  address_mat_a <= address_mat_a + TSTEP;
                  address_mat_b <= address_mat_b + TSTEP;
                  start_mat_mul <= 1'b1;
                  state         <= RUN;
               end else if (!n_last) begin
                  // B tiles of column n+1 follow directly after those of column n
                  address_mat_a <= a_row;
                  address_mat_b <= address_mat_b + TSTEP;
                  address_mat_c <= address_mat_c + TSTEP;
                  pe_reset      <= 1'b1;
                  state         <= CLR;
               end else if (!m_last) begin
                  address_mat_a <= address_mat_a + TSTEP;
                  a_row         <= address_mat_a + TSTEP;
                  address_mat_b <= bb;
                  address_mat_c <= address_mat_c + TSTEP;
                  pe_reset      <= 1'b1;
                  state         <= CLR;
               end else begin
                  state <= FIN;
               end
            end
            FIN: begin
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
